// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the pipeline-to-hazard-controller signals of the RISC-V core.
//   Optional feature macro used by the controller: HAZARD_PERF_CNT_EN.
//
//   Requests (pipeline -> controller):
//     loaduse_hazard_i  ID load-use dependency
//     je_i, jump_addr_i EX branch/jump taken and its target
//     mem_wait_i        MEM data memory not ready (level)
//     mc_start_i        EX multi-cycle op issued (pulse)
//     mc_len_i          multi-cycle op length, sampled with mc_start_i
//     trap_i            exception/interrupt taken
//     trap_addr_i       trap vector
//   Responses (controller -> pipeline):
//     stall_o           per-stage hold
//     flush_o           per-stage bubble
//     redirect_o        PC loads redirect_addr_o
//     redirect_addr_o   redirect target
//     mc_done_o         last stall cycle of a multi-cycle op
//
//   Modports: master = pipeline side, slave = hazard controller.
// ----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned MC_CNT_W   = 6
);

  logic                  loaduse_hazard_i;
  logic                  je_i;
  logic [XLEN-1:0]       jump_addr_i;
  logic                  mem_wait_i;
  logic                  mc_start_i;
  logic [MC_CNT_W-1:0]   mc_len_i;
  logic                  trap_i;
  logic [XLEN-1:0]       trap_addr_i;

  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic                  redirect_o;
  logic [XLEN-1:0]       redirect_addr_o;
  logic                  mc_done_o;

  modport master (
    output loaduse_hazard_i,
    output je_i,
    output jump_addr_i,
    output mem_wait_i,
    output mc_start_i,
    output mc_len_i,
    output trap_i,
    output trap_addr_i,
    input  stall_o,
    input  flush_o,
    input  redirect_o,
    input  redirect_addr_o,
    input  mc_done_o
  );

  modport slave (
    input  loaduse_hazard_i,
    input  je_i,
    input  jump_addr_i,
    input  mem_wait_i,
    input  mc_start_i,
    input  mc_len_i,
    input  trap_i,
    input  trap_addr_i,
    output stall_o,
    output flush_o,
    output redirect_o,
    output redirect_addr_o,
    output mc_done_o
  );

endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard/redirect controller. Merges trap, data-memory wait,
//   multi-cycle EX op, branch/jump and load-use requests (in that strict
//   priority) into per-stage stall/flush vectors and a single PC redirect.
//   A small counter FSM holds the front of the pipe while a multi-cycle op
//   (mul/div) occupies EX.
//
//   Stage bits: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB; any bit above 4
//   follows bit 4. Flush of a stage always overrides its stall.
//
//   Ports:
//     clk    core clock
//     rst_n  asynchronous active-low reset; forces all outputs to 0 while low
//     bus    hazard_ctrl_if.slave (requests in, stall/flush/redirect out)
//   Optional (macro HAZARD_PERF_CNT_EN defined):
//     perf_stall_cyc_o  cycles with stall_o[0] set (wraps at 2^32)
//     perf_flush_cnt_o  redirect events (wraps at 2^32)
//   Without HAZARD_PERF_CNT_EN those ports and counters do not exist.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned MC_CNT_W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  perf_stall_cyc_o,
  output logic [31:0]  perf_flush_cnt_o
`endif
);

  // FSM encoding kept as plain constants for compatibility with older tools.
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StMcBusy = 1'b1;

  // Canonical 5-bit stage patterns (bit4 = MEM/WB ... bit0 = PC).
  localparam logic [4:0] PatNone      = 5'b00000;
  localparam logic [4:0] TrapFlush    = 5'b11110;
  localparam logic [4:0] MemWaitStall = 5'b01111;
  localparam logic [4:0] MemWaitFlush = 5'b10000;
  localparam logic [4:0] McStall      = 5'b00111;
  localparam logic [4:0] McFlush      = 5'b01000;
  localparam logic [4:0] JumpFlush    = 5'b00110;
  localparam logic [4:0] LuStall      = 5'b00011;
  localparam logic [4:0] LuFlush      = 5'b00100;

  localparam logic [MC_CNT_W-1:0] CntOne  = MC_CNT_W'(1);
  localparam logic [MC_CNT_W-1:0] CntZero = '0;

  // Widen a 5-bit pattern to NUM_STAGES bits; stages beyond MEM/WB copy bit4.
  function automatic logic [NUM_STAGES-1:0] expand(input logic [4:0] pat);
    logic [NUM_STAGES-1:0] res;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      res[i] = pat[4];
      if (i < 5) begin
        res[i] = pat[i[2:0]];
      end
    end
    return res;
  endfunction

  logic [0:0]          state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;

  // A busy state with a zero count cannot finish normally; it is treated as
  // idle for output purposes and recovered on the next edge.
  logic busy_live;
  logic idle_mc_issue;

  assign busy_live     = (state_q == StMcBusy) && (cnt_q != CntZero);
  assign idle_mc_issue = (state_q == StIdle) && bus.mc_start_i && (bus.mc_len_i != CntZero);

  // --------------------------------------------------------------------------
  // Next-state: only trap aborts an op; mem_wait does not freeze the counter
  // because the multi-cycle unit keeps computing regardless of MEM.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.trap_i) begin
      state_d = StIdle;
      cnt_d   = CntZero;
    end else if (state_q == StMcBusy) begin
      if (cnt_q <= CntOne) begin
        state_d = StIdle;
        cnt_d   = CntZero;
      end else begin
        cnt_d = cnt_q - CntOne;
      end
    end else if (!bus.mem_wait_i && bus.mc_start_i && (bus.mc_len_i > CntOne)) begin
      // The issue cycle itself is the first stall cycle.
      state_d = StMcBusy;
      cnt_d   = bus.mc_len_i - CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= CntZero;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode, strict priority.
  // --------------------------------------------------------------------------
  logic [4:0]      stall_pat;
  logic [4:0]      flush_pat;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            mc_done;

  always_comb begin
    stall_pat     = PatNone;
    flush_pat     = PatNone;
    redirect      = 1'b0;
    redirect_addr = '0;
    mc_done       = 1'b0;
    if (!rst_n) begin
      // Everything stays quiet while held in reset.
      stall_pat = PatNone;
    end else if (bus.trap_i) begin
      flush_pat     = TrapFlush;
      redirect      = 1'b1;
      redirect_addr = bus.trap_addr_i;
    end else if (bus.mem_wait_i) begin
      // EX keeps its branch/mc request and re-presents it once MEM is ready.
      stall_pat = MemWaitStall;
      flush_pat = MemWaitFlush;
      mc_done   = busy_live && (cnt_q == CntOne);
    end else if (busy_live) begin
      stall_pat = McStall;
      flush_pat = McFlush;
      mc_done   = (cnt_q == CntOne);
    end else if (idle_mc_issue) begin
      stall_pat = McStall;
      flush_pat = McFlush;
      mc_done   = (bus.mc_len_i == CntOne);
    end else if ((state_q == StIdle) && bus.je_i && !bus.mc_start_i) begin
      // The instruction in ID is wrong-path, so any load-use on it is moot.
      flush_pat     = JumpFlush;
      redirect      = 1'b1;
      redirect_addr = bus.jump_addr_i;
    end else if (bus.loaduse_hazard_i) begin
      stall_pat = LuStall;
      flush_pat = LuFlush;
    end
  end

  logic [NUM_STAGES-1:0] stall_vec;
  logic [NUM_STAGES-1:0] flush_vec;

  always_comb begin
    flush_vec = expand(flush_pat);
    stall_vec = expand(stall_pat) & ~flush_vec;
  end

  assign bus.stall_o         = stall_vec;
  assign bus.flush_o         = flush_vec;
  assign bus.redirect_o      = redirect;
  assign bus.redirect_addr_o = redirect_addr;
  assign bus.mc_done_o       = mc_done;

`ifdef HAZARD_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters; free-running and wrapping.
  // --------------------------------------------------------------------------
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_vec[0]) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (redirect) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
